// File: rtl/vj_accum_calculator.sv
// Viola-Jones feature slice: integral + squared integral image of one window, then one
// three-rectangle Haar feature thresholded against a std-dev scaled threshold.
module vj_accum_calculator #(
    parameter int WINDOW_SIZE   = 24,
    parameter int RECT1_X       = 0,
    parameter int RECT1_Y       = 0,
    parameter int RECT1_WIDTH   = 1,
    parameter int RECT1_HEIGHT  = 1,
    parameter int RECT1_WEIGHT  = 1,
    parameter int RECT2_X       = 0,
    parameter int RECT2_Y       = 0,
    parameter int RECT2_WIDTH   = 1,
    parameter int RECT2_HEIGHT  = 1,
    parameter int RECT2_WEIGHT  = 1,
    parameter int RECT3_X       = 0,
    parameter int RECT3_Y       = 0,
    parameter int RECT3_WIDTH   = 1,
    parameter int RECT3_HEIGHT  = 1,
    parameter int RECT3_WEIGHT  = -1,
    parameter int FEAT_THRES    = 0,
    parameter int FEAT_ABOVE    = 0,
    parameter int FEAT_BELOW    = 0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    input  logic [WINDOW_SIZE:0][WINDOW_SIZE:0][31:0]  input_img,
    input  logic [31:0]                                scan_win_std_dev,
    output logic                                       int_valid,
    output logic [WINDOW_SIZE:0][WINDOW_SIZE:0][31:0]  scan_win,
    output logic [WINDOW_SIZE:0][WINDOW_SIZE:0][31:0]  scan_win_sq,
    output logic                                       out_valid,
    output logic [31:0]                                feature_accum
);

    localparam int N = WINDOW_SIZE + 1;

    localparam int RX  [3] = '{RECT1_X,      RECT2_X,      RECT3_X};
    localparam int RY  [3] = '{RECT1_Y,      RECT2_Y,      RECT3_Y};
    localparam int RW  [3] = '{RECT1_WIDTH,  RECT2_WIDTH,  RECT3_WIDTH};
    localparam int RH  [3] = '{RECT1_HEIGHT, RECT2_HEIGHT, RECT3_HEIGHT};
    localparam int RWT [3] = '{RECT1_WEIGHT, RECT2_WEIGHT, RECT3_WEIGHT};

    localparam logic signed [63:0] THRES64 = 64'(FEAT_THRES);
    localparam logic [31:0]        ABOVE32 = 32'(FEAT_ABOVE);
    localparam logic [31:0]        BELOW32 = 32'(FEAT_BELOW);

    logic [N-1:0][N-1:0][31:0] scan_win_next;
    logic [N-1:0][N-1:0][31:0] scan_win_sq_next;
    logic [31:0]               std_dev_reg;

    // Row prefix sums folded into the running column totals of the rows above.
    always_comb begin
        logic [31:0] row_acc;
        logic [31:0] row_acc_sq;
        logic [31:0] px;
        logic [31:0] col_acc    [N];
        logic [31:0] col_acc_sq [N];
        scan_win_next    = '0;
        scan_win_sq_next = '0;
        row_acc          = '0;
        row_acc_sq       = '0;
        px               = '0;
        for (int c = 0; c < N; c++) begin
            col_acc[c]    = '0;
            col_acc_sq[c] = '0;
        end
        for (int r = 0; r < N; r++) begin
            row_acc    = '0;
            row_acc_sq = '0;
            for (int c = 0; c < N; c++) begin
                px                     = input_img[r][c];
                row_acc                = row_acc + px;
                row_acc_sq             = row_acc_sq + px * px;
                col_acc[c]             = col_acc[c] + row_acc;
                col_acc_sq[c]          = col_acc_sq[c] + row_acc_sq;
                scan_win_next[r][c]    = col_acc[c];
                scan_win_sq_next[r][c] = col_acc_sq[c];
            end
        end
    end

    logic signed [31:0] rect_term [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_rect
            localparam int X0 = RX[gi];
            localparam int Y0 = RY[gi];
            localparam int X1 = RX[gi] + RW[gi];
            localparam int Y1 = RY[gi] + RH[gi];
            localparam logic signed [31:0] WT = 32'(RWT[gi]);

            if (X0 < 0 || Y0 < 0 || X1 > WINDOW_SIZE || Y1 > WINDOW_SIZE) begin : g_bad_rect
                $fatal(1, "vj_accum_calculator: rectangle %0d exceeds the window", gi + 1);
            end else if (RWT[gi] == 0) begin : g_zero_weight
                assign rect_term[gi] = '0;
            end else begin : g_weighted
                logic signed [31:0] rect_sum;
                assign rect_sum = $signed(scan_win[Y1][X1]) - $signed(scan_win[Y0][X1])
                                - $signed(scan_win[Y1][X0]) + $signed(scan_win[Y0][X0]);
                assign rect_term[gi] = rect_sum * WT;
            end
        end
    endgenerate

    logic signed [31:0] feature_sum;
    logic signed [63:0] feature_scaled;
    logic signed [63:0] thres_scaled;

    // Feature scaled by 4096 compared against threshold times the (unsigned) std-dev.
    assign feature_sum    = rect_term[0] + rect_term[1] + rect_term[2];
    assign feature_scaled = {{20{feature_sum[31]}}, feature_sum, 12'b0};
    assign thres_scaled   = THRES64 * $signed({32'd0, std_dev_reg});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_valid     <= 1'b0;
            out_valid     <= 1'b0;
            scan_win      <= '0;
            scan_win_sq   <= '0;
            std_dev_reg   <= '0;
            feature_accum <= '0;
        end else begin
            int_valid <= in_valid;
            out_valid <= int_valid;
            if (in_valid) begin
                scan_win    <= scan_win_next;
                scan_win_sq <= scan_win_sq_next;
                std_dev_reg <= scan_win_std_dev;
            end
            if (int_valid) begin
                feature_accum <= (feature_scaled < thres_scaled) ? BELOW32 : ABOVE32;
            end
        end
    end

endmodule

// File: tb/tb_vj_accum_calculator.sv
// Bench for vj_accum_calculator: table of windows driven back-to-back, scoreboard queues
// for integral images and votes, plus directed reset and boundary sequences.
module tb_vj_accum_calculator;

    localparam int WS = 24;
    localparam int N  = WS + 1;

    typedef logic [N-1:0][N-1:0][31:0] img_t;

    typedef struct {
        int          mode;      // 0 uniform, 1 random 32-bit, 2 random 8-bit
        logic [31:0] val;
        logic [31:0] std_dev;
        bit          use_model;
        logic [31:0] exp_acc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    img_t        input_img = '0;
    logic [31:0] std_dev = '0;
    logic        int_valid;
    img_t        scan_win;
    img_t        scan_win_sq;
    logic        out_valid;
    logic [31:0] feature_accum;

    vj_accum_calculator #(
        .WINDOW_SIZE(WS),
        .RECT1_X(0), .RECT1_Y(0), .RECT1_WIDTH(6), .RECT1_HEIGHT(6), .RECT1_WEIGHT(1),
        .RECT2_X(6), .RECT2_Y(6), .RECT2_WIDTH(6), .RECT2_HEIGHT(6), .RECT2_WEIGHT(1),
        .RECT3_X(4), .RECT3_Y(4), .RECT3_WIDTH(4), .RECT3_HEIGHT(4), .RECT3_WEIGHT(-1),
        .FEAT_THRES(128), .FEAT_ABOVE(6), .FEAT_BELOW(-6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .input_img(input_img),
        .scan_win_std_dev(std_dev),
        .int_valid(int_valid),
        .scan_win(scan_win),
        .scan_win_sq(scan_win_sq),
        .out_valid(out_valid),
        .feature_accum(feature_accum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int out_cycles = 0;

    img_t        sw_q[$];
    img_t        sq_q[$];
    logic [31:0] acc_q[$];
    img_t        mon_sw;
    img_t        mon_sq;
    logic [31:0] mon_acc;

    vec_t vecs[10];

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_img(string name, img_t act, img_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int y = 0; y < N; y++)
                for (int x = 0; x < N; x++)
                    if (act[y][x] !== exp[y][x]) begin
                        $display("FAIL %s [%0d][%0d] actual=%0h required=%0h",
                                 name, y, x, act[y][x], exp[y][x]);
                        return;
                    end
        end
    endtask

    // Reference: direct double sum per cell, independent of any prefix-sum scheme.
    function automatic img_t ref_int(img_t img, bit sq);
        img_t        r;
        logic [31:0] s;
        logic [31:0] p;
        r = '0;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++) begin
                s = '0;
                for (int i = 0; i <= y; i++)
                    for (int j = 0; j <= x; j++) begin
                        p = img[i][j];
                        s = s + (sq ? p * p : p);
                    end
                r[y][x] = s;
            end
        return r;
    endfunction

    function automatic logic [31:0] rect(img_t w, int x, int y, int wd, int ht);
        return w[y+ht][x+wd] - w[y][x+wd] - w[y+ht][x] + w[y][x];
    endfunction

    function automatic logic [31:0] ref_accum(img_t w, logic [31:0] sd);
        logic [31:0] f;
        longint      lhs;
        longint      rhs;
        longint      sd64;
        f    = rect(w, 0, 0, 6, 6) + rect(w, 6, 6, 6, 6) - rect(w, 4, 4, 4, 4);
        lhs  = longint'(signed'(f)) * 64'sd4096;
        sd64 = {32'd0, sd};
        rhs  = 64'sd128 * sd64;
        return (lhs < rhs) ? 32'hFFFF_FFFA : 32'd6;
    endfunction

    function automatic img_t make_img(int mode, logic [31:0] val);
        img_t r;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                case (mode)
                    1:       r[y][x] = $urandom;
                    2:       r[y][x] = $urandom_range(0, 255);
                    default: r[y][x] = val;
                endcase
        return r;
    endfunction

    task automatic send(img_t img, logic [31:0] sd, logic [31:0] exp_acc);
        input_img = img;
        std_dev   = sd;
        in_valid  = 1'b1;
        sw_q.push_back(ref_int(img, 1'b0));
        sq_q.push_back(ref_int(img, 1'b1));
        acc_q.push_back(exp_acc);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((acc_q.size() != 0 || sw_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        check32("drain_pending", 32'(acc_q.size() + sw_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: pop expected results whenever the DUT flags a valid output.
    always @(negedge clk) begin
        if (!rst) begin
            if (int_valid) begin
                if (sw_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL int_valid_unexpected actual=1 required=0");
                end else begin
                    mon_sw = sw_q.pop_front();
                    mon_sq = sq_q.pop_front();
                    check_img("scan_win", scan_win, mon_sw);
                    check_img("scan_win_sq", scan_win_sq, mon_sq);
                    $display("int  t=%0t scan_win[24][24]=%0h sq[24][24]=%0h",
                             $time, scan_win[WS][WS], scan_win_sq[WS][WS]);
                end
            end
            if (out_valid) begin
                out_cycles++;
                if (acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_valid_unexpected actual=1 required=0");
                end else begin
                    mon_acc = acc_q.pop_front();
                    check32("feature_accum", feature_accum, mon_acc);
                    $display("out  t=%0t feature_accum=%0d", $time, $signed(feature_accum));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        img_t img;
        logic [31:0] exp;

        vecs[0] = '{0, 32'd2,      32'd3584,      1'b0, 32'd6};
        vecs[1] = '{0, 32'd2,      32'd4000,      1'b0, 32'hFFFF_FFFA};
        vecs[2] = '{0, 32'd2,      32'd3584,      1'b0, 32'd6};
        vecs[3] = '{0, 32'd1,      32'd3584,      1'b0, 32'hFFFF_FFFA};
        vecs[4] = '{0, 32'd0,      32'd0,         1'b0, 32'd6};
        vecs[5] = '{0, 32'd0,      32'd1,         1'b0, 32'hFFFF_FFFA};
        vecs[6] = '{0, 32'hFFFF,   32'd3584,      1'b0, 32'd6};
        vecs[7] = '{0, 32'hFFFF,   32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFA};
        vecs[8] = '{1, 32'd0,      $urandom,      1'b1, 32'd0};
        vecs[9] = '{2, 32'd0,      32'd3584,      1'b1, 32'd0};

        // Reset state
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check32("rst_int_valid", 32'(int_valid), 32'd0);
        check32("rst_out_valid", 32'(out_valid), 32'd0);
        check32("rst_feature_accum", feature_accum, 32'd0);
        check_img("rst_scan_win", scan_win, '0);
        check_img("rst_scan_win_sq", scan_win_sq, '0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single all-2 window with spot checks on the integral image
        send(make_img(0, 32'd2), 32'd3584, 32'd6);
        in_valid = 1'b0;
        begin
            int n = 0;
            while (!int_valid && n < 5) begin
                @(negedge clk);
                n++;
            end
        end
        check32("int_valid_n1", 32'(int_valid), 32'd1);
        check32("scan_win_9_9", scan_win[9][9], 32'd200);
        check32("scan_win_sq_9_9", scan_win_sq[9][9], 32'd400);
        drain(8);

        // Table burst on consecutive cycles
        out_cycles = 0;
        foreach (vecs[k]) begin
            img = make_img(vecs[k].mode, vecs[k].val);
            exp = vecs[k].use_model ? ref_accum(ref_int(img, 1'b0), vecs[k].std_dev)
                                    : vecs[k].exp_acc;
            send(img, vecs[k].std_dev, exp);
        end
        in_valid = 1'b0;
        drain(10);
        check32("burst_out_cycles", 32'(out_cycles), 32'd10);
        @(negedge clk);
        check32("out_valid_drop", 32'(out_valid), 32'd0);

        // Asynchronous reset with a window in flight
        @(posedge clk);
        #1;
        send(make_img(0, 32'd3), 32'd3584, 32'd6);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        sw_q.delete();
        sq_q.delete();
        acc_q.delete();
        #1;
        check32("async_int_valid", 32'(int_valid), 32'd0);
        check32("async_out_valid", 32'(out_valid), 32'd0);
        check32("async_feature_accum", feature_accum, 32'd0);
        check_img("async_scan_win", scan_win, '0);
        check_img("async_scan_win_sq", scan_win_sq, '0);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("post_rst_out_valid", 32'(out_valid), 32'd0);
        end

        // Normal operation after release
        @(posedge clk);
        #1;
        send(make_img(0, 32'd2), 32'd4000, 32'hFFFF_FFFA);
        in_valid = 1'b0;
        drain(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vj_accum_calculator.md
# vj_accum_calculator

Clocked Viola-Jones feature-evaluation slice. It builds the integral image and the squared integral image of one scan window. It then evaluates one three-rectangle Haar feature on that window and returns the feature's stage-accumulator contribution (above/below vote) against a variance-normalised threshold. It sits between the window scanner, which supplies pixels and the window standard deviation, and the stage accumulator/classifier.

## Interface
Parameters:
- WINDOW_SIZE, 24: window edge. Arrays are (WINDOW_SIZE+1)×(WINDOW_SIZE+1); row 0 and column 0 are zero padding.
- RECTn_X / RECTn_Y (n=1..3), 0: rectangle top-left, in integral-image coordinates.
- RECTn_WIDTH / RECTn_HEIGHT, 1: rectangle size.
- RECTn_WEIGHT, 1 (RECT3: -1): signed integer weight.
- FEAT_THRES, 0: signed feature threshold.
- FEAT_ABOVE, 0: signed vote when the feature is at or above threshold.
- FEAT_BELOW, 0: signed vote when the feature is below threshold.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: input window valid this cycle.
- input_img, in, (WINDOW_SIZE+1)²×32: packed pixels, [row][col][31:0], unsigned.
- scan_win_std_dev, in, 32: unsigned window standard deviation, sampled with in_valid.
- int_valid, out, 1: scan_win/scan_win_sq valid.
- scan_win, out, (WINDOW_SIZE+1)²×32: integral image.
- scan_win_sq, out, (WINDOW_SIZE+1)²×32: squared integral image.
- out_valid, out, 1: feature_accum valid.
- feature_accum, out, 32: signed vote (FEAT_ABOVE or FEAT_BELOW).

## Operation
- Integral stage:
  - scan_win[y][x] = Σ input_img[i][j] over i≤y, j≤x.
  - scan_win_sq[y][x] = Σ input_img[i][j]² over the same range.
  - All arithmetic is 32-bit, wrapping mod 2³².
  - Nonzero padding pixels are summed like any other pixel; no masking.
- Rectangle sum: R = W[Y+H][X+W] − W[Y][X+W] − W[Y+H][X] + W[Y][X], computed on scan_win as signed 32-bit.
- Feature: F = Σ RECTn_WEIGHT·Rn, signed 32-bit, wrapping.
- Decision:
  - Compare (F · 4096) against FEAT_THRES · scan_win_std_dev, both in signed 64-bit.
  - If F·4096 < FEAT_THRES·std_dev, feature_accum = FEAT_BELOW; otherwise FEAT_ABOVE. Equality yields FEAT_ABOVE.
- Elaboration-time requirement: RECTn_X+RECTn_WIDTH ≤ WINDOW_SIZE and RECTn_Y+RECTn_HEIGHT ≤ WINDOW_SIZE; violation is a fatal elaboration error.
- A rectangle with weight 0 contributes nothing.

## Timing
- Two-stage pipeline, one window accepted per cycle, no back-pressure.
- Cycle N, in_valid=1: input_img and scan_win_std_dev are captured.
- N+1: scan_win, scan_win_sq and int_valid=1 are registered; std_dev is carried along in a register.
- N+2: feature_accum and out_valid=1 are registered from the N+1 contents.
- in_valid=0: valid bits shift a 0. Data registers hold their last value, and the held value is don't-care to consumers.
- Back-to-back windows on consecutive cycles each produce output exactly 2 cycles later, in order.
- Reset, asynchronous on rst high:
  - int_valid, out_valid, scan_win, scan_win_sq, feature_accum and the internal std_dev register go to 0 immediately.
  - Windows in flight are discarded.
  - The first capture happens on the first rising edge with rst low.

## Test plan
- All-2 window, WINDOW_SIZE=24, in_valid pulse -> at N+1, scan_win[y][x]=2(y+1)(x+1) and scan_win_sq[y][x]=4(y+1)(x+1), e.g. [9][9]=200 / 400.
- Feature rects (0,0,6,6,+1), (6,6,6,6,+1), (4,4,4,4,−1), thres 128, above 6, below −6, same all-2 image, std_dev=3584 -> F=112, 458752 == 458752 -> feature_accum=6 at N+2, out_valid=1.
- Same setup, std_dev=4000 -> 458752 < 512000 -> feature_accum=−6 (0xFFFFFFFA).
- Three distinct windows on consecutive cycles (std_dev 3584, 4000, 3584) -> outputs 6, −6, 6 on consecutive cycles starting at N+2; out_valid stays high for 3 cycles, then drops.
- rst asserted asynchronously between N and N+2 -> all outputs and both valid bits read 0 at once, no out_valid for that window; normal operation resumes after release.
- Pixel value 0xFFFF at every position -> scan_win_sq wraps mod 2³² and matches a 32-bit reference model bit-exactly.
